dna_reader: RTL and testbench
=============================

// Module: dna_reader
// PURPOSE
//  Upstream front-end for device-ID handling: drives the serial device-DNA primitive port
//  (READ/SHIFT/DIN/DOUT) and assembles the 57-bit DNA into a parallel word with a valid flag.
//  Consumers (ID compare, licence gate, register readback) use dna_value once dna_valid is set.
//  Reads once after reset and again on request.
// PARAMETERS
//  DNA_WIDTH       57  number of DNA bits shifted out, MSB first
//  START_ON_RESET  1   1: a read starts automatically after reset; 0: wait for start
// PORTS
//  clk        in   1          system clock; all logic on rising edge
//  reset      in   1          synchronous, active-high reset
//  start      in   1          single-cycle request to re-read; ignored while busy
//  dna_dout   in   1          DOUT from DNA primitive
//  dna_read   out  1          READ to primitive: parallel-load DNA into its shift register
//  dna_shift  out  1          SHIFT to primitive: shift one bit per clk
//  dna_din    out  1          DIN to primitive
//  busy       out  1          read sequence in progress
//  dna_valid  out  1          dna_value holds a complete, checked DNA
//  dna_value  out  DNA_WIDTH  captured DNA, bit DNA_WIDTH-1 = first bit out
//  dna_error  out  1          rollover check failed (constant 0 when feature compiled out)
// BEHAVIOUR
//  - One clock domain; synchronous, active-high reset.
//  - Reset: all outputs 0. State = IDLE. Internal pending flag = START_ON_RESET.
//    Reset mid-sequence aborts it; READ and SHIFT drop at that edge.
//  - Cycle numbering: cycle 0 is the first cycle with reset low.
//  - FSM states: IDLE, LOAD, SHIFT, VERIFY (feature only), DONE. All outputs are registered.
//  - IDLE / DONE: (pending | start) -> LOAD at the next edge.
//    That edge clears pending, dna_valid, dna_error and dna_value; busy=1.
//  - LOAD: dna_read=1 for exactly one cycle (cycle 1 on the auto-start path); bit_cnt<=0.
//    Goes to SHIFT.
//  - SHIFT: dna_shift=1. At the end of each cycle, sr <= {sr[W-2:0], dna_dout}; bit_cnt++.
//    After the sample with bit_cnt==W-1 (W cycles total): next state is DONE, or VERIFY
//    with the feature. sr is internal; dna_value is loaded from sr on the same edge.
//  - DONE: busy=0, dna_valid=1 (unless dna_error), dna_value stable until the next start.
//  - Timing without feature: dna_shift high in cycles 2..W+1. Valid first seen in cycle W+2
//    (59 at default). busy high in cycles 1..W+1.
//  - start while busy is ignored (not queued). start in the same cycle as reset is ignored.
//  - bit_cnt is 6 bits (enough for W<=64) and never wraps within a pass.
//  - dna_din=0 without feature.
// CONFIGURATION
//  - Macro DNA_ROLLOVER_CHECK_EN.
//  - Defined:
//    - During SHIFT, dna_din = dna_dout (combinational loop-back), so the primitive register
//      rotates back to the original DNA.
//    - SHIFT is followed by VERIFY: dna_shift=1 for another W cycles with dna_din=dna_dout.
//      Each sampled bit is compared against dna_value, MSB first.
//    - Any mismatch sets dna_error=1 at DONE entry and dna_valid stays 0. dna_value still
//      shows the first-pass capture.
//    - Valid/error first seen in cycle 2W+2 (116 at default). busy high in cycles 1..2W+1.
//  - Undefined: no VERIFY state, dna_din tied 0, dna_error tied 0.
// TESTING
//  1. Primitive model loaded with 57'h028340E18D8C85C, reset released -> dna_read high only
//     in cycle 1, dna_shift high for 57 cycles, dna_valid=1 in cycle 59,
//     dna_value=57'h028340E18D8C85C.
//  2. start pulse in DONE -> dna_valid=0 the next cycle, one new READ pulse,
//     dna_valid=1 again 59 cycles after start, same value.
//  3. start pulses in cycles 10 and 40 during the first read -> exactly one READ pulse total,
//     completion in cycle 59.
//  4. reset held in cycles 30-31 mid-shift -> all outputs 0 in cycle 32. Read restarts;
//     valid 59 cycles after release with the correct value.
//  5. START_ON_RESET=0 -> no READ/SHIFT for 200 cycles after reset; start -> valid 59 cycles
//     later.
//  6. DNA_ROLLOVER_CHECK_EN:
//     - Good model -> dna_error=0, dna_valid=1 in cycle 116.
//     - Model flips DOUT bit 5 on the second pass -> dna_error=1, dna_valid=0.

Source files
------------

// File: rtl/dna_reader.sv
// Reads the serial device-DNA primitive once after reset (and on request) and presents it as a parallel word.
// Optional rollover check: define DNA_ROLLOVER_CHECK_EN.
module dna_reader #(
  parameter int DNA_WIDTH      = 57,
  parameter bit START_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 dna_dout,
  output logic                 dna_read,
  output logic                 dna_shift,
  output logic                 dna_din,
  output logic                 busy,
  output logic                 dna_valid,
  output logic [DNA_WIDTH-1:0] dna_value,
  output logic                 dna_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [5:0] LAST    = 6'(DNA_WIDTH - 1);

  logic [2:0]           state;
  logic                 pending;
  logic [5:0]           bit_cnt;
  // The final bit goes straight into dna_value, so sr only needs W-1 bits.
  logic [DNA_WIDTH-2:0] sr;

`ifdef DNA_ROLLOVER_CHECK_EN
  localparam logic [2:0] S_VERIFY = 3'd3;

  logic       mismatch;
  logic [5:0] vidx;
  logic       bit_bad;

  assign vidx    = LAST - bit_cnt;
  assign bit_bad = (dna_dout != dna_value[vidx]);
  // Loop DOUT back into DIN so the primitive rotates back to the original DNA.
  assign dna_din = (state == S_SHIFT || state == S_VERIFY) ? dna_dout : 1'b0;
`else
  assign dna_din   = 1'b0;
  assign dna_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pending   <= START_ON_RESET;
      bit_cnt   <= '0;
      sr        <= '0;
      dna_read  <= 1'b0;
      dna_shift <= 1'b0;
      busy      <= 1'b0;
      dna_valid <= 1'b0;
      dna_value <= '0;
`ifdef DNA_ROLLOVER_CHECK_EN
      mismatch  <= 1'b0;
      dna_error <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (pending || start) begin
            state     <= S_LOAD;
            pending   <= 1'b0;
            dna_valid <= 1'b0;
            dna_value <= '0;
            busy      <= 1'b1;
            dna_read  <= 1'b1;
`ifdef DNA_ROLLOVER_CHECK_EN
            dna_error <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          state     <= S_SHIFT;
          dna_read  <= 1'b0;
          dna_shift <= 1'b1;
          bit_cnt   <= '0;
        end
        S_SHIFT: begin
          sr      <= {sr[DNA_WIDTH-3:0], dna_dout};
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == LAST) begin
            dna_value <= {sr, dna_dout};
`ifdef DNA_ROLLOVER_CHECK_EN
            state     <= S_VERIFY;
            bit_cnt   <= '0;
            mismatch  <= 1'b0;
`else
            state     <= S_DONE;
            dna_shift <= 1'b0;
            busy      <= 1'b0;
            dna_valid <= 1'b1;
`endif
          end
        end
`ifdef DNA_ROLLOVER_CHECK_EN
        S_VERIFY: begin
          bit_cnt  <= bit_cnt + 6'd1;
          mismatch <= mismatch | bit_bad;
          if (bit_cnt == LAST) begin
            state     <= S_DONE;
            dna_shift <= 1'b0;
            busy      <= 1'b0;
            dna_error <= mismatch | bit_bad;
            dna_valid <= !(mismatch | bit_bad);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_reader.sv
// Scoreboard bench for dna_reader: two instances (auto-start and start-on-request) each driven by a
// behavioural DNA primitive; completions are popped from per-instance expectation queues.
module tb_dna_reader;

  localparam int          W   = 57;
  localparam logic [56:0] VAL = 57'h028340E18D8C85C;
`ifdef DNA_ROLLOVER_CHECK_EN
  localparam int DONE_C  = 2 * W + 2;
  localparam int SHIFT_N = 2 * W;
`else
  localparam int DONE_C  = W + 2;
  localparam int SHIFT_N = W;
`endif
  localparam int FLIP_AT = W + (W - 1 - 5);

  typedef struct {
    logic [56:0] value;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, start_nr, flip_en;
  int   cyc = 0;

  logic dna_dout, dna_read, dna_shift, dna_din, busy, dna_valid, dna_error;
  logic [W-1:0] dna_value;
  logic dout_nr, read_nr, shift_nr, din_nr, busy_nr, valid_nr, error_nr;
  logic [W-1:0] value_nr;

  logic [W-1:0] prim = '0, prim_nr = '0;
  int sh_cnt = 0;

  exp_t exp_q[$], exp_nr_q[$];
  int vectors = 0, miscompares = 0;
  int read_cnt = 0, shift_cnt = 0, read_first = -1;
  int read_cnt_nr = 0, shift_cnt_nr = 0;
  logic done_prev = 1'b0, done_prev_nr = 1'b0;

  dna_reader dut (
    .clk(clk), .reset(reset), .start(start), .dna_dout(dna_dout),
    .dna_read(dna_read), .dna_shift(dna_shift), .dna_din(dna_din), .busy(busy),
    .dna_valid(dna_valid), .dna_value(dna_value), .dna_error(dna_error)
  );

  dna_reader #(.START_ON_RESET(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .start(start_nr), .dna_dout(dout_nr),
    .dna_read(read_nr), .dna_shift(shift_nr), .dna_din(din_nr), .busy(busy_nr),
    .dna_valid(valid_nr), .dna_value(value_nr), .dna_error(error_nr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Primitive models: READ loads the DNA, SHIFT moves one bit toward DOUT and takes DIN at the bottom.
  always @(posedge clk) begin
    if (dna_read) begin
      prim   <= VAL;
      sh_cnt <= 0;
    end else if (dna_shift) begin
      prim   <= {prim[W-2:0], dna_din};
      sh_cnt <= sh_cnt + 1;
    end
    if (read_nr)       prim_nr <= VAL;
    else if (shift_nr) prim_nr <= {prim_nr[W-2:0], din_nr};
  end

  assign dna_dout = prim[W-1] ^ (flip_en && sh_cnt == FLIP_AT);
  assign dout_nr  = prim_nr[W-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compareDone(input string tag, input exp_t e, input logic [W-1:0] value,
                             input logic valid, input logic err);
    checkOutput({tag, "_value"}, 64'(value), 64'(e.value));
    checkOutput({tag, "_error"}, 64'(err), 64'(e.err));
    checkOutput({tag, "_valid"}, 64'(valid), 64'(!e.err));
    checkOutput({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
  endtask

  // Monitors: a completion is the rising edge of (valid | error).
  always @(negedge clk) begin
    exp_t e;
    logic done_now;
    done_now = dna_valid | dna_error;
    if (done_now === 1'b1 && done_prev === 1'b0) begin
      if (exp_q.size() == 0) checkOutput("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        compareDone("done", e, dna_value, dna_valid, dna_error);
      end
    end
    done_prev = done_now;
    if (dna_read === 1'b1) begin
      if (read_cnt == 0) read_first = cyc;
      read_cnt++;
    end
    if (dna_shift === 1'b1) shift_cnt++;
  end

  always @(negedge clk) begin
    exp_t e;
    logic done_now;
    done_now = valid_nr | error_nr;
    if (done_now === 1'b1 && done_prev_nr === 1'b0) begin
      if (exp_nr_q.size() == 0) checkOutput("nr_unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
      else begin
        e = exp_nr_q.pop_front();
        compareDone("nr_done", e, value_nr, valid_nr, error_nr);
      end
    end
    done_prev_nr = done_now;
    if (read_nr === 1'b1)  read_cnt_nr++;
    if (shift_nr === 1'b1) shift_cnt_nr++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goTo(input int n);
    int k = 0;
    while (cyc != n && k < 1000) begin
      step();
      k++;
    end
    if (cyc != n) checkOutput("goto_timeout", 64'(cyc), 64'(n));
  endtask

  task automatic clearCounts();
    read_cnt     = 0;
    shift_cnt    = 0;
    read_first   = -1;
    read_cnt_nr  = 0;
    shift_cnt_nr = 0;
  endtask

  task automatic pushExp(input logic err, input int c);
    exp_t e;
    e.value = VAL;
    e.err   = err;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic waitDone();
    int k = 0;
    while ((exp_q.size() != 0 || exp_nr_q.size() != 0) && k < 400) begin
      step();
      k++;
    end
    if (exp_q.size() != 0 || exp_nr_q.size() != 0) begin
      checkOutput("done_timeout", 64'(exp_q.size() + exp_nr_q.size()), 64'd0);
      exp_q.delete();
      exp_nr_q.delete();
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_read"},  64'(dna_read),  64'd0);
    checkOutput({tag, "_shift"}, 64'(dna_shift), 64'd0);
    checkOutput({tag, "_din"},   64'(dna_din),   64'd0);
    checkOutput({tag, "_busy"},  64'(busy),      64'd0);
    checkOutput({tag, "_valid"}, 64'(dna_valid), 64'd0);
    checkOutput({tag, "_value"}, 64'(dna_value), 64'd0);
    checkOutput({tag, "_error"}, 64'(dna_error), 64'd0);
  endtask

  task automatic applyStimulus();
    int s;
    exp_t e;

    // Reset state.
    reset = 1'b1; start = 1'b0; start_nr = 1'b0; flip_en = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset_nr_busy", 64'(busy_nr), 64'd0);

    // Auto-start read with two start pulses that must be ignored while busy.
    step();
    reset = 1'b0;
    clearCounts();
    pushExp(1'b0, DONE_C);
    goTo(10); start = 1'b1; step(); start = 1'b0;
    goTo(40); start = 1'b1; step(); start = 1'b0;
    waitDone();
    step();
    checkOutput("t1_read_count", 64'(read_cnt),   64'd1);
    checkOutput("t1_read_cycle", 64'(read_first), 64'd1);
    checkOutput("t1_shift_cnt",  64'(shift_cnt),  64'(SHIFT_N));
    checkOutput("t1_busy_done",  64'(busy),       64'd0);

    // Re-read on request from DONE.
    s = DONE_C + 5;
    goTo(s);
    clearCounts();
    pushExp(1'b0, s + DONE_C);
    start = 1'b1; step(); start = 1'b0;
    @(negedge clk);
    checkOutput("t2_valid_cleared", 64'(dna_valid), 64'd0);
    checkOutput("t2_read_pulse",    64'(dna_read),  64'd1);
    checkOutput("t2_busy",          64'(busy),      64'd1);
    step(); step();
    @(negedge clk);
    checkOutput("t2_din", 64'(dna_din), 64'(`ifdef DNA_ROLLOVER_CHECK_EN dna_dout `else 1'b0 `endif));
    waitDone();
    checkOutput("t2_read_count", 64'(read_cnt), 64'd1);

    // Reset mid-shift aborts the read; start_nr held with reset must be ignored.
    step();
    reset = 1'b1; step(); step();
    reset = 1'b0;
    goTo(30);
    reset = 1'b1; start_nr = 1'b1;
    step(); step();
    reset = 1'b0; start_nr = 1'b0;
    clearCounts();
    pushExp(1'b0, DONE_C);
    @(negedge clk);
    checkAllZero("t4_abort");
    waitDone();

    // START_ON_RESET=0 instance stays idle until asked.
    goTo(200);
    checkOutput("t5_nr_reads",  64'(read_cnt_nr),  64'd0);
    checkOutput("t5_nr_shifts", 64'(shift_cnt_nr), 64'd0);
    checkOutput("t5_nr_busy",   64'(busy_nr),      64'd0);
    e.value = VAL; e.err = 1'b0; e.cyc = 200 + DONE_C;
    exp_nr_q.push_back(e);
    start_nr = 1'b1; step(); start_nr = 1'b0;
    waitDone();
    checkOutput("t5_nr_read_count", 64'(read_cnt_nr), 64'd1);

`ifdef DNA_ROLLOVER_CHECK_EN
    // Corrupted second pass must raise dna_error and keep dna_valid low.
    step();
    s = cyc;
    flip_en = 1'b1;
    pushExp(1'b1, s + DONE_C);
    start = 1'b1; step(); start = 1'b0;
    waitDone();
    flip_en = 1'b0;
`endif
  endtask

  initial begin
    applyStimulus();
    repeat (2) step();
    checkOutput("queue_empty", 64'(exp_q.size() + exp_nr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
